// File: rtl/rv32i_pkg.sv
// RV32I opcode constants and a load/store decode helper shared by the core's control blocks.
package rv32i_pkg;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    function automatic logic is_mem_op(input logic [6:0] opcode);
        return (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE);
    endfunction

endpackage

// File: rtl/interlock_unit_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/interlock_unit.sv
// Pipeline interlock generator: combinational stall plus stall-cause flags, sticky watchdog and
// optional per-cause stall counters (build with INTERLOCK_PERF_EN to get the counters).
module interlock_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ack_n,
    input  logic             dmem_ack_n,
    input  logic [6:0]       opcode,
    output logic             interlock,
    output logic             imem_stall,
    output logic             dmem_stall,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] imem_stall_cnt,
    output logic [CNT_W-1:0] dmem_stall_cnt
);

    // Pure decode, no state: valid while rst_n is low.
    assign imem_stall = imem_ack_n;
    assign dmem_stall = dmem_ack_n & is_mem_op(opcode);
    assign interlock  = imem_stall | dmem_stall;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int            RW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT_CYCLES - 1);

            logic [RW-1:0] run_cnt;
            logic          stall_timeout_d;
            logic          stall_timeout_q;

            sat_counter #(.W(RW)) u_run_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (~interlock),
                .inc   (interlock),
                .cnt   (run_cnt)
            );

            // Sticky: only reset clears it once the run has reached its limit.
            always_comb begin
                stall_timeout_d = stall_timeout_q | (interlock && (run_cnt == RUN_LAST));
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stall_timeout_q <= 1'b0;
                end else begin
                    stall_timeout_q <= stall_timeout_d;
                end
            end

            assign stall_timeout = stall_timeout_q;
        end else begin : g_no_wdog
            assign stall_timeout = 1'b0;
        end
    endgenerate

`ifdef INTERLOCK_PERF_EN
    sat_counter #(.W(CNT_W)) u_imem_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (imem_stall),
        .cnt   (imem_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dmem_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (dmem_stall),
        .cnt   (dmem_stall_cnt)
    );
`else
    assign imem_stall_cnt = {CNT_W{1'b0}};
    assign dmem_stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_interlock_unit.sv
// Directed bench for interlock_unit (TIMEOUT_CYCLES=4); perf-counter checks follow INTERLOCK_PERF_EN.
module tb_interlock_unit;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             imem_ack_n;
    logic             dmem_ack_n;
    logic [6:0]       opcode;
    logic             interlock;
    logic             imem_stall;
    logic             dmem_stall;
    logic             stall_timeout;
    logic [CNT_W-1:0] imem_stall_cnt;
    logic [CNT_W-1:0] dmem_stall_cnt;

    int errors = 0;
    int checks = 0;

    interlock_unit #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_ack_n     (imem_ack_n),
        .dmem_ack_n     (dmem_ack_n),
        .opcode         (opcode),
        .interlock      (interlock),
        .imem_stall     (imem_stall),
        .dmem_stall     (dmem_stall),
        .stall_timeout  (stall_timeout),
        .imem_stall_cnt (imem_stall_cnt),
        .dmem_stall_cnt (dmem_stall_cnt)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle on the falling edge where outputs are sampled and inputs driven.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        imem_ack_n = 1'b1;
        dmem_ack_n = 1'b1;
        opcode     = 7'b0000011;
        tick();
        tick();
        checks++;
        if (stall_timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout got=%b exp=0", stall_timeout);
        end
        checks++;
        if (imem_stall_cnt !== '0 || dmem_stall_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", imem_stall_cnt, dmem_stall_cnt);
        end
        // Combinational path works while held in reset.
        checks++;
        if ({interlock, imem_stall, dmem_stall} !== 3'b111) begin
            errors++; $display("FAIL reset_comb got=%b exp=111", {interlock, imem_stall, dmem_stall});
        end
        imem_ack_n = 1'b0;
        dmem_ack_n = 1'b0;
        opcode     = 7'b0110011;
        rst_n      = 1'b1;
        tick();
    endtask

    // Each row: {imem_ack_n, dmem_ack_n} -> expected {interlock, imem_stall, dmem_stall}.
    task automatic test_decode(input logic [6:0] op, input logic [11:0] exp_tbl, input string name);
        logic [1:0] acks;
        logic [2:0] exp;
        for (int i = 0; i < 4; i++) begin
            acks       = 2'(i);
            exp        = exp_tbl[11 - 3*i -: 3];
            opcode     = op;
            imem_ack_n = acks[1];
            dmem_ack_n = acks[0];
            #1;
            checks++;
            if ({interlock, imem_stall, dmem_stall} !== exp) begin
                errors++;
                $display("FAIL %s_ack%b got=%b exp=%b", name, acks,
                         {interlock, imem_stall, dmem_stall}, exp);
            end
        end
        imem_ack_n = 1'b0;
        dmem_ack_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        test_decode(7'b0000011, {3'b000, 3'b101, 3'b110, 3'b111}, "load");
    endtask

    task automatic test_store();
        test_decode(7'b0100011, {3'b000, 3'b101, 3'b110, 3'b111}, "store");
    endtask

    task automatic test_rtype();
        test_decode(7'b0110011, {3'b000, 3'b000, 3'b110, 3'b110}, "rtype");
        test_decode(7'b1111111, {3'b000, 3'b000, 3'b110, 3'b110}, "illegal");
    endtask

    task automatic test_watchdog();
        opcode     = 7'b0110011;
        dmem_ack_n = 1'b1;
        imem_ack_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (stall_timeout !== (i == 4)) begin
                errors++; $display("FAIL wdog_edge%0d got=%b exp=%b", i, stall_timeout, (i == 4));
            end
        end
        imem_ack_n = 1'b0;
        tick();
        tick();
        checks++;
        if (stall_timeout !== 1'b1) begin
            errors++; $display("FAIL wdog_sticky got=%b exp=1", stall_timeout);
        end
        checks++;
        if (interlock !== 1'b0) begin
            errors++; $display("FAIL wdog_interlock got=%b exp=0", interlock);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (stall_timeout !== 1'b0) begin
            errors++; $display("FAIL wdog_async_clear got=%b exp=0", stall_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // A stall broken by reset must restart the run count from zero.
    task automatic test_wdog_reset_mid_stall();
        imem_ack_n = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (stall_timeout !== (i == 4)) begin
                errors++; $display("FAIL wdog_restart_edge%0d got=%b exp=%b", i, stall_timeout, (i == 4));
            end
        end
        imem_ack_n = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_perf();
        logic [CNT_W-1:0] exp_i;
        logic [CNT_W-1:0] exp_d;
`ifdef INTERLOCK_PERF_EN
        exp_i = CNT_W'(3);
        exp_d = CNT_W'(2);
`else
        exp_i = '0;
        exp_d = '0;
`endif
        opcode     = 7'b0110011;
        dmem_ack_n = 1'b1;
        imem_ack_n = 1'b1;
        repeat (3) tick();
        imem_ack_n = 1'b0;
        opcode     = 7'b0000011;
        repeat (2) tick();
        dmem_ack_n = 1'b0;
        tick();
        checks++;
        if (imem_stall_cnt !== exp_i) begin
            errors++; $display("FAIL perf_imem got=%0d exp=%0d", imem_stall_cnt, exp_i);
        end
        checks++;
        if (dmem_stall_cnt !== exp_d) begin
            errors++; $display("FAIL perf_dmem got=%0d exp=%0d", dmem_stall_cnt, exp_d);
        end
        dmem_ack_n = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_stall_cnt !== '0 || dmem_stall_cnt !== '0) begin
            errors++; $display("FAIL perf_async_clear got=%0d/%0d exp=0/0", imem_stall_cnt, dmem_stall_cnt);
        end
        @(negedge clk);
        dmem_ack_n = 1'b0;
        rst_n      = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_rtype();
        test_watchdog();
        test_wdog_reset_mid_stall();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
